hp_controller: RTL
==================

HP_CONTROLLER -- requirements
Module: hp_controller

Interface
REQ-001 The block SHALL have parameter MAX_HP, default 120, giving the full hit-point count (one HP = one bar pixel).
REQ-002 The block SHALL have parameter STEP_DIV, default 2, giving the number of frame_tick pulses per 1-HP animation step (legal range 1..15).
REQ-003 Port clk: input, 1 bit, single system clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port frame_tick: input, 1 bit, one-cycle pulse once per video frame.
REQ-006 Port dmg_valid: input, 1 bit, damage request.
REQ-007 Port dmg_amt: input, 7 bits, damage amount in HP.
REQ-008 Port heal_valid: input, 1 bit, heal request.
REQ-009 Port heal_amt: input, 7 bits, heal amount in HP.
REQ-010 Port revive: input, 1 bit, one-cycle pulse that restores a fainted unit.
REQ-011 Port req_ready: output, 1 bit, high when a damage or heal request will be accepted this cycle.
REQ-012 Port blood: output, 10 bits, bar fill extent in pixels relative to x0 (2 = empty, 2+MAX_HP = full).
REQ-013 Port busy: output, 1 bit, high while the bar is animating.
REQ-014 Port fainted: output, 1 bit, high while HP is 0 and the animation has settled.

Function
REQ-015 The block SHALL hold an internal hp register, 7 bits, range 0..MAX_HP, and a target register of the same width.
REQ-016 blood SHALL equal hp + 2, zero-extended to 10 bits and registered, so that blood updates one cycle after hp.
REQ-017 The FSM SHALL have the states IDLE, DRAIN, FILL and FAINTED.
REQ-018 req_ready SHALL be high only in IDLE.
REQ-019 busy SHALL be high only in DRAIN or FILL.
REQ-020 fainted SHALL be high only in FAINTED.
REQ-021 Damage SHALL be accepted in IDLE when dmg_valid=1.
- On acceptance, target = hp - dmg_amt, saturating at 0.
- The next state is DRAIN.
REQ-022 Heal SHALL be accepted in IDLE when heal_valid=1 and dmg_valid=0; damage wins a simultaneous request, and the heal is dropped with no queuing.
- On acceptance, target = hp + heal_amt, saturating at MAX_HP.
- The next state is FILL.
REQ-023 A request whose saturated target equals hp SHALL be accepted with no state change: the FSM stays in IDLE and busy stays low.
REQ-024 A 4-bit step counter SHALL clear on every accepted request.
- In DRAIN or FILL, the counter increments on each frame_tick.
- When frame_tick=1 and counter=STEP_DIV-1, a step fires and the counter clears.
REQ-025 On a step, DRAIN SHALL decrement hp by 1 and FILL SHALL increment hp by 1.
REQ-026 When hp reaches target (the cycle after the final step), the FSM SHALL move from DRAIN to FAINTED if hp=0, otherwise to IDLE, and SHALL move from FILL to IDLE.
REQ-027 With N = |target-hp|, the Nth step SHALL occur on the (N*STEP_DIV)th frame_tick after acceptance; frame_tick in the acceptance cycle SHALL NOT count.
REQ-028 The FSM SHALL ignore dmg_valid and heal_valid in DRAIN, FILL and FAINTED.
REQ-029 revive SHALL be honoured only in FAINTED.
- It sets hp = MAX_HP and target = MAX_HP.
- The next state is IDLE.
- revive is ignored in all other states.
REQ-030 hp SHALL never leave the range 0..MAX_HP, and blood SHALL never leave the range 2..2+MAX_HP.

Reset
REQ-031 On rst=1, asynchronously and regardless of state, the block SHALL set:
- hp = MAX_HP, target = MAX_HP
- blood = 2+MAX_HP (122 at default)
- state = IDLE, step counter = 0
- req_ready = 1, busy = 0, fainted = 0
REQ-032 A reset asserted mid-animation SHALL abandon the animation, and the block SHALL accept a request on the first clock edge after rst deasserts.

Verification
REQ-033 Reset with defaults -> blood=122, req_ready=1, busy=0, fainted=0.
REQ-034 From full HP, dmg_amt=10 and STEP_DIV=2, then 20 frame_ticks -> blood steps 122 down to 112, one pixel per 2 ticks; busy falls after the last step; req_ready returns to 1.
REQ-035 With hp=5, dmg_amt=40 -> hp saturates at 0, blood=2, fainted=1; a subsequent dmg_valid is ignored; revive -> blood=122, state IDLE.
REQ-036 With hp=110, heal_amt=30 -> FILL stops at blood=122 (hp=120); dmg_valid and heal_valid together in IDLE -> damage taken, heal dropped.
REQ-037 dmg_valid held during DRAIN -> no extra acceptance; req_ready=0 throughout; hp reaches only the first target.
REQ-038 rst pulsed at blood=117 mid-DRAIN -> blood=122 immediately; busy=0; a new request is accepted on the next cycle.

Source files
------------

// File: rtl/hp_controller.sv
// hp_controller: hit-point bar controller.
// Requests set a target HP; the bar then drains or fills one HP per
// STEP_DIV frame ticks until it reaches the target. A unit drained to
// zero parks in FAINTED until revived.
module hp_controller #(
    parameter int MAX_HP   = 120,
    parameter int STEP_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       dmg_valid,
    input  logic [6:0] dmg_amt,
    input  logic       heal_valid,
    input  logic [6:0] heal_amt,
    input  logic       revive,
    output logic       req_ready,
    output logic [9:0] blood,
    output logic       busy,
    output logic       fainted
);

    localparam logic [6:0] HP_FULL    = 7'(MAX_HP);
    localparam logic [3:0] STEP_LAST  = 4'(STEP_DIV - 1);
    localparam logic [9:0] BLOOD_FULL = 10'(MAX_HP + 2);

    typedef enum logic [1:0] {IDLE, DRAIN, FILL, FAINTED} state_t;

    state_t     state, state_nx;
    logic [6:0] hp, hp_nx;
    logic [6:0] target, target_nx;
    logic [3:0] cnt, cnt_nx;
    logic [6:0] dmg_tgt, heal_tgt;
    logic [7:0] heal_sum;

    // Saturated candidate targets for a damage or heal request.
    always_comb begin
        dmg_tgt  = (hp > dmg_amt) ? (hp - dmg_amt) : '0;
        heal_sum = {1'b0, hp} + {1'b0, heal_amt};
        heal_tgt = (heal_sum > {1'b0, HP_FULL}) ? HP_FULL : heal_sum[6:0];
    end

    // State, hp, target and step counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hp     <= HP_FULL;
            target <= HP_FULL;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            hp     <= hp_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
        end
    end

    // Next-state logic: request acceptance, stepping and settling.
    always_comb begin
        state_nx  = state;
        hp_nx     = hp;
        target_nx = target;
        cnt_nx    = cnt;
        case (state)
            IDLE: begin
                // Damage wins over a simultaneous heal; a no-op target stays in IDLE.
                if (dmg_valid) begin
                    cnt_nx    = '0;
                    target_nx = dmg_tgt;
                    if (dmg_tgt != hp) state_nx = DRAIN;
                end else if (heal_valid) begin
                    cnt_nx    = '0;
                    target_nx = heal_tgt;
                    if (heal_tgt != hp) state_nx = FILL;
                end
            end
            DRAIN, FILL: begin
                if (hp == target) begin
                    state_nx = (state == DRAIN && hp == '0) ? FAINTED : IDLE;
                end else if (frame_tick) begin
                    if (cnt == STEP_LAST) begin
                        cnt_nx = '0;
                        hp_nx  = (state == DRAIN) ? (hp - 7'd1) : (hp + 7'd1);
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            FAINTED: begin
                if (revive) begin
                    hp_nx     = HP_FULL;
                    target_nx = HP_FULL;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state == DRAIN) || (state == FILL);
        fainted   = (state == FAINTED);
    end

    // Bar extent register, one cycle behind hp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blood <= BLOOD_FULL;
        else     blood <= {3'b000, hp} + 10'd2;
    end

endmodule
